// File: rtl/fdivsqrt_otf_fgen_r4.sv
// fdivsqrt_otf_fgen_r4: radix-4 on-the-fly root/quotient conversion and residual addend generator
module fdivsqrt_otf_fgen_r4 #(
  parameter int W = 28,
  parameter int ITER = 13
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        sqrt_mode,
  input  logic [W-1:0]                d_in,
  input  logic                        stall,
  input  logic [3:0]                  udigit,
  output logic                        busy,
  output logic                        done,
  output logic [W-1:0]                U,
  output logic [W-1:0]                UM,
  output logic [W-1:0]                F,
  output logic                        f_cin,
  output logic [$clog2(ITER+1)-1:0]   iter_cnt
);
  localparam int CW = $clog2(ITER+1);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [W-1:0] c, d, k1, k2, fs, fd;
  logic mode, p2, p1, m1, m2, step;
  assign p2 = udigit[3];
  assign p1 = ~udigit[3] & udigit[2];
  assign m1 = udigit[3:1] == 3'b001;
  assign m2 = udigit == 4'b0001;
  assign k1 = c & ~(c << 1);
  assign k2 = k1 << 1;
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  assign step = busy & ~stall;
  assign fs = p2 ? (~U << 2) & (c << 2) :
              p1 ? ~(U << 1) & c :
              m1 ? (UM << 1) | (c & ~(c << 3)) :
              m2 ? (UM << 2) | ((c << 2) & ~(c << 4)) : '0;
  assign fd = p2 ? ~(d << 1) : p1 ? ~d : m1 ? d : m2 ? d << 1 : '0;
  assign F = busy ? (mode ? fs : fd) : '0;
  assign f_cin = busy & ~mode & (p2 | p1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      U <= '0;
      UM <= '0;
      c <= '0;
      d <= '0;
      mode <= 1'b0;
      iter_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      U <= '0;
      UM <= '0;
      c <= {2'b11, {(W-2){1'b0}}};
      d <= d_in;
      mode <= sqrt_mode;
      iter_cnt <= '0;
      state <= S_RUN;
    end else if (step) begin
      U <= p2 ? U | k2 : p1 ? U | k1 : m1 ? UM | k2 | k1 : m2 ? UM | k2 : U;
      UM <= p2 ? U | k1 : p1 ? U : m1 ? UM | k2 : m2 ? UM | k1 : UM | k2 | k1;
      c <= {2'b11, c[W-1:2]};
      iter_cnt <= iter_cnt + CW'(1);
      if (iter_cnt == CW'(ITER-1)) state <= S_DONE;
    end else if (done) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_fdivsqrt_otf_fgen_r4.sv
// tb_fdivsqrt_otf_fgen_r4: randomized check against an arithmetic model of the digit sum
module tb_fdivsqrt_otf_fgen_r4;
  localparam int W = 8;
  localparam int ITER = 3;
  logic clk = 1'b0, reset, start, sqrt_mode, stall, busy, done, f_cin;
  logic [W-1:0] d_in, U, UM, F;
  logic [3:0] udigit;
  logic [$clog2(ITER+1)-1:0] iter_cnt;
  int n_vec = 0, n_err = 0;
  int msum, mk;
  logic [W-1:0] mu, mum, md;
  bit msq;
  always #5 clk = ~clk;
  fdivsqrt_otf_fgen_r4 #(.W(W), .ITER(ITER)) dut (
    .clk(clk), .reset(reset), .start(start), .sqrt_mode(sqrt_mode), .d_in(d_in),
    .stall(stall), .udigit(udigit), .busy(busy), .done(done), .U(U), .UM(UM),
    .F(F), .f_cin(f_cin), .iter_cnt(iter_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int dig(input logic [3:0] u);
    return u[3] ? 2 : u[2] ? 1 : u[1] ? -1 : u[0] ? -2 : 0;
  endfunction
  function automatic logic [W-1:0] cmask(input int k);
    logic [W-1:0] m;
    m = '1;
    return m << (W - 2*(k+1));
  endfunction
  function automatic logic [W-1:0] fexp(input logic [3:0] u);
    logic [W-1:0] c;
    c = cmask(mk);
    if (msq)
      case (dig(u))
        2: return (~mu << 2) & (c << 2);
        1: return ~(mu << 1) & c;
        -1: return (mum << 1) | (c & ~(c << 3));
        -2: return (mum << 2) | ((c << 2) & ~(c << 4));
        default: return '0;
      endcase
    case (dig(u))
      2: return ~(md << 1);
      1: return ~md;
      -1: return md;
      -2: return md << 1;
      default: return '0;
    endcase
  endfunction
  task automatic begin_op(input bit s, input logic [W-1:0] dv);
    start = 1'b1;
    sqrt_mode = s;
    d_in = dv;
    udigit = 4'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    sqrt_mode = 1'($urandom);
    d_in = W'($urandom);
    msum = 0; mk = 0; mu = '0; mum = '0; md = dv; msq = s;
    chk("start_busy", busy, 1);
    chk("start_U", U, 0);
    chk("start_UM", UM, 0);
    chk("start_cnt", iter_cnt, 0);
  endtask
  task automatic step(input logic [3:0] u);
    int w;
    udigit = u;
    stall = 1'b0;
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    chk("F", F, fexp(u));
    chk("f_cin", f_cin, (!msq && dig(u) > 0));
    @(posedge clk); #1;
    w = 1 << (W - 2 - 2*mk);
    msum += dig(u) * w;
    mu = W'(msum);
    mum = W'(msum - w);
    mk++;
    chk("U", U, mu);
    chk("UM", UM, mum);
    chk("cnt", iter_cnt, mk);
  endtask
  task automatic stall_cyc();
    udigit = 4'($urandom);
    stall = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_done", done, 0);
    chk("stall_F", F, fexp(udigit));
    @(posedge clk); #1;
    stall = 1'b0;
    start = 1'b0;
    chk("stall_U", U, mu);
    chk("stall_UM", UM, mum);
    chk("stall_cnt", iter_cnt, mk);
  endtask
  task automatic end_op();
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    udigit = 4'b0100;
    @(negedge clk);
    chk("done_F", F, 0);
    chk("done_cin", f_cin, 0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("hold_U", U, mu);
    chk("hold_UM", UM, mum);
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; sqrt_mode = 1'b0; d_in = '0; udigit = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_U", U, 0);
    chk("rst_UM", UM, 0);
    chk("rst_cnt", iter_cnt, 0);
    udigit = 4'b1000;
    #1 chk("rst_F", F, 0);
    @(posedge clk); #1;
    begin_op(1'b1, '0);
    step(4'b0100);
    chk("sq1_U", U, 8'b0100_0000);
    step(4'b0010);
    chk("sq2_U", U, 8'b0011_0000);
    chk("sq2_UM", UM, 8'b0010_0000);
    step(4'b1000);
    chk("sq3_U", U, 8'b0011_1000);
    chk("sq3_UM", UM, 8'b0011_0100);
    end_op();
    begin_op(1'b0, 8'b0001_0110);
    udigit = 4'b0100;
    #1 chk("div_p1_F", F, 8'b1110_1001);
    step(4'b0100);
    step(4'b0001);
    step(4'b0000);
    end_op();
    begin_op(1'b1, W'($urandom));
    step(4'($urandom));
    stall_cyc();
    stall_cyc();
    step(4'($urandom));
    step(4'($urandom));
    end_op();
    begin_op(1'b0, W'($urandom));
    step(4'($urandom));
    step(4'($urandom));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    udigit = 4'b0100;
    @(negedge clk);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_U", U, 0);
    chk("mid_UM", UM, 0);
    chk("mid_F", F, 0);
    chk("mid_cnt", iter_cnt, 0);
    @(posedge clk); #1;
    begin_op(1'b1, W'($urandom));
    for (int i = 0; i < ITER; i++) step(4'($urandom));
    end_op();
    begin_op(1'b0, 8'h5a);
    step(4'b0110);
    step(4'b1111);
    step(4'b0011);
    end_op();
    repeat (40) begin
      begin_op(1'($urandom), W'($urandom));
      for (int i = 0; i < ITER; i++) begin
        if ($urandom_range(3) == 0) stall_cyc();
        step(4'($urandom));
      end
      end_op();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fdivsqrt_otf_fgen_r4.md
Name: fdivsqrt_otf_fgen_r4

Overview:
- Sequential radix-4 digit-recurrence helper for the divide/square-root unit.
- Holds the on-the-fly conversion state (root/quotient U, U minus one ulp UM) and the position mask C, and generates the residual addend F plus carry-in from each one-hot digit.
- Supports divide and square-root modes and has a fixed-length iteration controller.
- Sits between the digit-selection logic and the residual carry-save adder.

Parameters:
- W, 28, width of U, UM, C, D and F in bits (DIVb+4); must be even and at least 6.
- ITER, 13, number of digits accepted per operation; must be at least 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  begin operation; honoured only in IDLE
- sqrt_mode  in  1  sampled at start; 1 = sqrt, 0 = divide
- d_in  in  W  aligned divisor; sampled at start
- stall  in  1  while high in RUN, no step is accepted and state is held
- udigit  in  4  one-hot digit {+2,+1,-1,-2} as bits [3:0]; all-zero means digit 0
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse in DONE
- U  out  W  converted result register
- UM  out  W  U minus one ulp register
- F  out  W  addend for the current digit
- f_cin  out  1  carry-in for the addend
- iter_cnt  out  $clog2(ITER+1)  digits accepted so far

Behaviour:
- Reset (synchronous, highest priority, also when it arrives mid-operation):
  - state=IDLE; U, UM, C, D register, mode and iter_cnt all 0.
  - busy=0, done=0, F=0, f_cin=0.
- States:
  - IDLE: on start, load U=0, UM=0, C={2'b11,0...}, D=d_in, mode=sqrt_mode, iter_cnt=0, then go to RUN.
  - RUN: a step is accepted on each cycle with stall=0.
    - On the ITER-th accepted step, go to DONE.
    - start is ignored while in RUN.
  - DONE: done=1 for exactly one cycle, then IDLE. U and UM hold their values until the next start.
- Digit decode uses priority bit3 > bit2 > bit1 > bit0, so a multi-hot digit is resolved to its highest-priority bit.
- Position mask:
  - K1 = C & ~(C<<1), the lowest set bit of C; K2 = K1<<1.
  - Each step: C <= {2'b11, C[W-1:2]}.
- On-the-fly update per accepted step:
  - +2: U<=U|K2, UM<=U|K1
  - +1: U<=U|K1, UM<=U
  - 0: U<=U, UM<=UM|K2|K1
  - -1: U<=UM|K2|K1, UM<=UM|K2
  - -2: U<=UM|K2, UM<=UM|K1
- F in sqrt mode (combinational from current registers and udigit):
  - +2: (~U<<2)&(C<<2)
  - +1: ~(U<<1)&C
  - 0: 0
  - -1: (UM<<1)|(C&~(C<<3))
  - -2: (UM<<2)|((C<<2)&~(C<<4))
- F in divide mode:
  - +2: ~(D<<1)
  - +1: ~D
  - 0: 0
  - -1: D
  - -2: D<<1
- Carry-in and gating:
  - f_cin = 1 for positive digits in divide mode, else 0.
  - Outside RUN, F=0 and f_cin=0.
- Shifts are logical and truncated to W bits. No other registered latency: F is valid in the same cycle udigit is applied.
- When stall=1 in the final step's cycle, DONE is delayed until that step is accepted.

Test Plan:
- Reset then idle, W=8, ITER=3 -> busy=0, done=0, U=UM=F=0, iter_cnt=0; udigit=4'b1000 gives F=0.
- Sqrt start, digits +1,-1,+2 on consecutive cycles -> U/UM after each step:
  - after +1: 0100_0000 / 0000_0000
  - after -1: 0011_0000 / 0010_0000
  - after +2: 0011_1000 / 0011_0100
  - done pulses the next cycle, then IDLE.
- Sqrt first cycle with udigit=+1, W=8 -> F=1100_0000, f_cin=0.
- Divide, d_in=0001_0110, W=8:
  - digit +1 -> F=1110_1001, f_cin=1
  - digit -2 -> F=0010_1100, f_cin=0
  - digit 0 -> F=0, f_cin=0
- stall held for 2 cycles mid-operation, plus start pulsed in RUN -> U, UM, C and iter_cnt unchanged; the restart is ignored; done arrives 2 cycles late.
- Reset asserted after the 2nd step -> next cycle IDLE with all outputs 0; a following start runs a full ITER-step operation correctly.
- Multi-hot udigit=4'b0110 -> treated as +1.
